// File: rtl/serial_adder_n_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// Optional `sub` line appears when SERIAL_ADDER_SUBTRACT_EN is defined.
interface serial_adder_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
`ifdef SERIAL_ADDER_SUBTRACT_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    modport master (
`ifdef SERIAL_ADDER_SUBTRACT_EN
        output sub,
`endif
        output start, a, b, carry_in,
        input  busy, done, sum, carry_out
    );

    modport slave (
`ifdef SERIAL_ADDER_SUBTRACT_EN
        input  sub,
`endif
        input  start, a, b, carry_in,
        output busy, done, sum, carry_out
    );
endinterface

// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first.
// Define SERIAL_ADDER_SUBTRACT_EN to add the `sub` (a - b) mode.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    serial_adder_n_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             c_q;
    logic             c_nxt;
    logic             s_bit;
    logic             co_q;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_init;
    logic             c_init;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the accept/last qualifiers
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = (cnt == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                accept = bus.start;
                if (bus.start) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                accept    = bus.start;
                state_nxt = bus.start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand preparation; subtract inverts B and forces carry to 1
    always_comb begin
        b_init = bus.b;
        c_init = bus.carry_in;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        if (bus.sub) begin
            b_init = ~bus.b;
            c_init = 1'b1;
        end
`endif
    end

    // Single full-adder cell and result shift toward the LSB
    always_comb begin
        s_bit            = a_sh[0] ^ b_sh[0] ^ c_q;
        c_nxt            = (a_sh[0] & b_sh[0]) |
                           (a_sh[0] & c_q) |
                           (b_sh[0] & c_q);
        res_nxt          = res_sh >> 1;
        res_nxt[WIDTH-1] = s_bit;
    end

    // Serial datapath: capture on accept, one bit per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            c_q    <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            co_q   <= 1'b0;
        end else if (accept) begin
            a_sh   <= bus.a;
            b_sh   <= b_init;
            c_q    <= c_init;
            res_sh <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            c_q    <= c_nxt;
            res_sh <= res_nxt;
            cnt    <= cnt + CW'(1);
            if (last) begin
                sum_q <= res_nxt;
                co_q  <= c_nxt;
            end
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.sum       = sum_q;
    assign bus.carry_out = co_q;
endmodule

// File: tb/tb_serial_adder_n.sv
// Scoreboard bench for serial_adder_n (WIDTH=8 and WIDTH=1 instances).
// Subtract cases run when SERIAL_ADDER_SUBTRACT_EN is defined.
module tb_serial_adder_n;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [8:0] q8[$];

    serial_adder_n_if #(.WIDTH(8)) bus8 ();
    serial_adder_n_if #(.WIDTH(1)) bus1 ();

    serial_adder_n #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    serial_adder_n #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results are compared when done is seen
    always @(negedge clk) begin
        if (!rst && bus8.done === 1'b1) begin
            if (q8.size() == 0) begin
                chk("spurious_done", 32'(bus8.done), 32'd0);
            end else begin
                chk("sum8", 32'({bus8.carry_out, bus8.sum}),
                    32'(q8.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go8(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic cin);
        bus8.start    = 1'b1;
        bus8.a        = a;
        bus8.b        = b;
        bus8.carry_in = cin;
        q8.push_back({1'b0, a} + {1'b0, b} + 9'(cin));
        step();
        bus8.start    = 1'b0;
    endtask

    task automatic wait_done8(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus8.done === 1'b1) break;
            step();
            cyc++;
        end
        if (bus8.done !== 1'b1) chk("timeout8", 32'(bus8.done), 32'd1);
    endtask

    int cyc;

    initial begin
        n_cmp         = 0;
        n_bad         = 0;
        rst           = 1'b1;
        bus8.start    = 1'b0;
        bus8.a        = '0;
        bus8.b        = '0;
        bus8.carry_in = 1'b0;
        bus1.start    = 1'b0;
        bus1.a        = '0;
        bus1.b        = '0;
        bus1.carry_in = 1'b0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
        bus8.sub      = 1'b0;
        bus1.sub      = 1'b0;
`endif
        repeat (3) step();
        rst = 1'b0;
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst_sum", 32'(bus8.sum), 32'd0);
        chk("rst_co", 32'(bus8.carry_out), 32'd0);
        step();

        // 0x5A + 0x3C with exact busy/done timing
        go8(8'h5A, 8'h3C, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("busy_c%0d", i), 32'(bus8.busy), 32'd1);
            chk($sformatf("done_c%0d", i), 32'(bus8.done), 32'd0);
            step();
        end
        chk("done_c9", 32'(bus8.done), 32'd1);
        chk("busy_c9", 32'(bus8.busy), 32'd0);
        chk("val_c9", 32'({bus8.carry_out, bus8.sum}), 32'h096);
        step();
        chk("done_c10", 32'(bus8.done), 32'd0);
        chk("hold_sum", 32'(bus8.sum), 32'h96);

        // 0xFF + 0x01 + 1, then back-to-back start in DONE
        go8(8'hFF, 8'h01, 1'b1);
        wait_done8(cyc);
        chk("lat_ff", 32'(cyc), 32'd8);
        bus8.start    = 1'b1;
        bus8.a        = 8'h01;
        bus8.b        = 8'h01;
        bus8.carry_in = 1'b0;
        q8.push_back(9'h002);
        step();
        bus8.start = 1'b0;
        chk("b2b_done", 32'(bus8.done), 32'd0);
        chk("b2b_busy", 32'(bus8.busy), 32'd1);
        chk("b2b_hold", 32'({bus8.carry_out, bus8.sum}), 32'h101);
        wait_done8(cyc);
        chk("lat_b2b", 32'(cyc), 32'd8);
        step();

        // start while busy must be ignored
        go8(8'h21, 8'h43, 1'b1);
        step();
        step();
        bus8.start    = 1'b1;
        bus8.a        = 8'hF0;
        bus8.b        = 8'hF0;
        bus8.carry_in = 1'b1;
        step();
        bus8.start    = 1'b0;
        bus8.a        = 8'h00;
        bus8.b        = 8'h00;
        wait_done8(cyc);
        repeat (12) step();
        chk("ign_q_empty", 32'(q8.size()), 32'd0);
        chk("ign_sum", 32'(bus8.sum), 32'h65);

        // reset in the middle of a run
        go8(8'h77, 8'h11, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q8.delete();
        chk("mid_busy", 32'(bus8.busy), 32'd0);
        chk("mid_done", 32'(bus8.done), 32'd0);
        chk("mid_sum", 32'(bus8.sum), 32'd0);
        chk("mid_co", 32'(bus8.carry_out), 32'd0);
        repeat (12) step();
        chk("mid_nodone", 32'(bus8.done), 32'd0);
        go8(8'hC3, 8'h5D, 1'b1);
        wait_done8(cyc);
        step();

        // random operands
        for (int i = 0; i < 6; i++) begin
            go8(8'($urandom), 8'($urandom), 1'($urandom));
            wait_done8(cyc);
            step();
        end

        // WIDTH=1: full-adder truth table
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v             = 3'(i);
            bus1.start    = 1'b1;
            bus1.a        = v[2];
            bus1.b        = v[1];
            bus1.carry_in = v[0];
            step();
            bus1.start    = 1'b0;
            bus1.a        = ~v[2];
            chk($sformatf("w1_busy%0d", i), 32'(bus1.busy), 32'd1);
            step();
            chk($sformatf("w1_done%0d", i), 32'(bus1.done), 32'd1);
            chk($sformatf("w1_val%0d", i),
                32'({bus1.carry_out, bus1.sum}),
                32'(v[2]) + 32'(v[1]) + 32'(v[0]));
            step();
        end

`ifdef SERIAL_ADDER_SUBTRACT_EN
        bus8.sub = 1'b1;
        bus8.start    = 1'b1;
        bus8.a        = 8'h10;
        bus8.b        = 8'h01;
        bus8.carry_in = 1'b0;
        q8.push_back(9'h10F);
        step();
        bus8.start = 1'b0;
        wait_done8(cyc);
        step();
        bus8.start    = 1'b1;
        bus8.a        = 8'h01;
        bus8.b        = 8'h02;
        bus8.carry_in = 1'b1;
        q8.push_back(9'h0FF);
        step();
        bus8.start = 1'b0;
        wait_done8(cyc);
        step();
        bus8.sub = 1'b0;
`endif

        repeat (3) step();
        chk("final_q_empty", 32'(q8.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
